// File: rtl/ifu_pkg.sv
// ============================================================================
// Module   : ifu_pkg
// Purpose  : Shared widths, reset address and fetch FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_pkg;

  localparam int          ISA_WIDTH    = 32;
  localparam logic [31:0] PC_BASE_ADDR = 32'h8000_0000;

  localparam logic [1:0] IFU_ST_IDLE = 2'd0;
  localparam logic [1:0] IFU_ST_REQ  = 2'd1;
  localparam logic [1:0] IFU_ST_WAIT = 2'd2;
  localparam logic [1:0] IFU_ST_OUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IFU_ST_IDLE,
    ST_REQ  = IFU_ST_REQ,
    ST_WAIT = IFU_ST_WAIT,
    ST_OUT  = IFU_ST_OUT
  } ifu_state_t;

endpackage

`default_nettype wire

// File: rtl/ifu_reg.sv
// ============================================================================
// Module   : Reg
// Purpose  : Generic enable register, asynchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_dout <= RESET_VAL;
    end else if (i_wen) begin
      o_dout <= i_din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifu.sv
// ============================================================================
// Module   : ifu
// Purpose  : Instruction fetch unit: PC -> imem request/response -> decode,
//            plus next-PC / redirect handling. Optional misaligned-fetch
//            fault enabled by defining IFU_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu
  import ifu_pkg::*;
#(
  parameter int XLEN   = ISA_WIDTH,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_in,
  output logic              pc_w_en,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_fault,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc
);

  ifu_state_t        r_state;
  ifu_state_t        w_next_state;
  logic [1:0]        w_state_q;
  logic              r_pend_valid;
  logic [XLEN-1:0]   r_pend_pc;
  logic              w_pend_en;
  logic              w_pend_valid_d;
  logic [XLEN-1:0]   w_pend_pc_d;
  logic              w_inst_en;
  logic [INST_W-1:0] w_inst_d;
  logic [XLEN-1:0]   w_inst_pc_d;
  logic              w_fault_d;
  logic              w_misalign;
  logic [XLEN-1:0]   w_pc_seq;
  logic              w_redir_any;
  logic [XLEN-1:0]   w_redir_tgt;

  assign w_pc_seq = pc + XLEN'(4);

`ifdef IFU_ALIGN_CHECK_EN
  assign w_misalign = (pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // A live redirect this cycle overrides an older pending one.
  assign w_redir_any = redirect_valid | r_pend_valid;
  assign w_redir_tgt = redirect_valid ? redirect_pc : r_pend_pc;

  always_comb begin
    w_next_state   = r_state;
    pc_w_en        = 1'b0;
    pc_in          = w_pc_seq;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc;
    inst_valid     = 1'b0;
    w_pend_en      = 1'b0;
    w_pend_valid_d = r_pend_valid;
    w_pend_pc_d    = r_pend_pc;
    w_inst_en      = 1'b0;
    w_inst_d       = imem_rsp_data;
    w_inst_pc_d    = pc;
    w_fault_d      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_next_state = ST_REQ;
        if (redirect_valid) begin
          pc_w_en = 1'b1;
          pc_in   = redirect_pc;
        end
      end

      ST_REQ: begin
        if (redirect_valid) begin
          w_pend_en      = 1'b1;
          w_pend_valid_d = 1'b1;
          w_pend_pc_d    = redirect_pc;
        end
        if (w_misalign) begin
          w_next_state = ST_OUT;
          w_inst_en    = 1'b1;
          w_inst_d     = '0;
          w_fault_d    = 1'b1;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            w_next_state = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          w_pend_en      = 1'b1;
          w_pend_valid_d = 1'b1;
          w_pend_pc_d    = redirect_pc;
        end
        if (imem_rsp_valid) begin
          w_inst_en = 1'b1;
          if (w_redir_any) begin
            pc_w_en        = 1'b1;
            pc_in          = w_redir_tgt;
            w_pend_en      = 1'b1;
            w_pend_valid_d = 1'b0;
            w_next_state   = ST_REQ;
          end else begin
            w_next_state = ST_OUT;
          end
        end
      end

      ST_OUT: begin
        // Pending only reaches OUT via a redirect during a faulting REQ.
        if (w_redir_any) begin
          pc_w_en        = 1'b1;
          pc_in          = w_redir_tgt;
          w_pend_en      = 1'b1;
          w_pend_valid_d = 1'b0;
          w_next_state   = ST_REQ;
        end else begin
          inst_valid = 1'b1;
          if (inst_ready) begin
            pc_w_en      = 1'b1;
            pc_in        = w_pc_seq;
            w_next_state = ST_REQ;
          end
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  Reg #(.WIDTH(2), .RESET_VAL(IFU_ST_IDLE)) u_state (
    .clk    (clk),
    .rst    (rst),
    .i_wen  (1'b1),
    .i_din  (w_next_state),
    .o_dout (w_state_q)
  );
  assign r_state = ifu_state_t'(w_state_q);

  Reg #(.WIDTH(1)) u_pend_valid (
    .clk    (clk),
    .rst    (rst),
    .i_wen  (w_pend_en),
    .i_din  (w_pend_valid_d),
    .o_dout (r_pend_valid)
  );

  Reg #(.WIDTH(XLEN)) u_pend_pc (
    .clk    (clk),
    .rst    (rst),
    .i_wen  (w_pend_en),
    .i_din  (w_pend_pc_d),
    .o_dout (r_pend_pc)
  );

  Reg #(.WIDTH(INST_W)) u_inst (
    .clk    (clk),
    .rst    (rst),
    .i_wen  (w_inst_en),
    .i_din  (w_inst_d),
    .o_dout (inst)
  );

  Reg #(.WIDTH(XLEN)) u_inst_pc (
    .clk    (clk),
    .rst    (rst),
    .i_wen  (w_inst_en),
    .i_din  (w_inst_pc_d),
    .o_dout (inst_pc)
  );

`ifdef IFU_ALIGN_CHECK_EN
  Reg #(.WIDTH(1)) u_fault (
    .clk    (clk),
    .rst    (rst),
    .i_wen  (w_inst_en),
    .i_din  (w_fault_d),
    .o_dout (inst_fault)
  );
`else
  logic w_unused_fault;
  assign w_unused_fault = w_fault_d;
  assign inst_fault     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu.sv
// ============================================================================
// Module   : tb_ifu
// Purpose  : Directed self-checking bench for ifu with a PC register and a
//            one-cycle-latency instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] pc_in;
  logic        pc_w_en;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] pc_rst_val = PC_BASE_ADDR;

  logic        m_hs;
  logic [31:0] m_addr;
  logic        m_we;
  logic [31:0] m_nx;

  always #5 clk = ~clk;

  ifu dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_in          (pc_in),
    .pc_w_en        (pc_w_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1234_5678);
  endfunction

  // PC register and memory: sample at the edge, update 1 time unit later.
  always @(posedge clk) begin
    m_hs   = imem_req_valid && imem_req_ready;
    m_addr = imem_req_addr;
    m_we   = pc_w_en;
    m_nx   = pc_in;
    #1;
    if (!rst) pc = pc_rst_val;
    else if (m_we) pc = m_nx;
    imem_rsp_valid = m_hs;
    imem_rsp_data  = m_hs ? mem_word(m_addr) : 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] rv);
    pc_rst_val = rv;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // Reset values
    pc_rst_val = PC_BASE_ADDR;
    tick();
    tick();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_pc_w_en", pc_w_en, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_fault", inst_fault, 0);

    // Basic fetch: IDLE, REQ, WAIT, OUT
    rst = 1'b1;
    check("c1_idle_req", imem_req_valid, 0);
    tick();
    check("c2_req_valid", imem_req_valid, 1);
    check("c2_req_addr", imem_req_addr, 32'h8000_0000);
    check("c2_pc_w_en", pc_w_en, 0);
    tick();
    check("c3_wait_valid", inst_valid, 0);
    tick();
    check("c4_inst_valid", inst_valid, 1);
    check("c4_inst", inst, 32'h0000_0413);
    check("c4_inst_pc", inst_pc, 32'h8000_0000);
    check("c4_fault", inst_fault, 0);
    inst_ready = 1'b1;
    #1;
    check("c4_pc_w_en", pc_w_en, 1);
    check("c4_pc_in", pc_in, 32'h8000_0004);
    tick();
    inst_ready = 1'b0;
    check("c5_pc_w_en", pc_w_en, 0);
    check("c5_req_addr", imem_req_addr, 32'h8000_0004);

    // Decode stall for 5 cycles
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", inst_valid, 1);
      check("stall_inst", inst, 32'h9234_567C);
      check("stall_pc_w_en", pc_w_en, 0);
      tick();
    end
    inst_ready = 1'b1;
    #1;
    check("stall_hs_w_en", pc_w_en, 1);
    check("stall_hs_pc_in", pc_in, 32'h8000_0008);
    tick();
    inst_ready = 1'b0;

    // Redirect in the same cycle as the WAIT response
    check("rw_req_addr", imem_req_addr, 32'h8000_0008);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    #1;
    check("rw_inst_valid", inst_valid, 0);
    check("rw_pc_w_en", pc_w_en, 1);
    check("rw_pc_in", pc_in, 32'h8000_0100);
    tick();
    redirect_valid = 1'b0;
    check("rw_next_addr", imem_req_addr, 32'h8000_0100);
    check("rw_next_vld", inst_valid, 0);

    // Redirect during a stalled REQ: request held, response then dropped
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    #1;
    check("rq_pc_w_en", pc_w_en, 0);
    tick();
    redirect_valid = 1'b0;
    check("rq_held_valid", imem_req_valid, 1);
    check("rq_held_addr", imem_req_addr, 32'h8000_0100);
    imem_req_ready = 1'b1;
    tick();
    check("rq_drop_valid", inst_valid, 0);
    check("rq_pc_w_en2", pc_w_en, 1);
    check("rq_pc_in", pc_in, 32'h8000_0200);
    tick();
    check("rq_next_addr", imem_req_addr, 32'h8000_0200);

    // Redirect and inst_ready together in OUT
    tick();
    tick();
    check("ro_pre_valid", inst_valid, 1);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    #1;
    check("ro_inst_valid", inst_valid, 0);
    check("ro_pc_w_en", pc_w_en, 1);
    check("ro_pc_in", pc_in, 32'h8000_0300);
    tick();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    check("ro_next_addr", imem_req_addr, 32'h8000_0300);

    // PC wrap at the top of the address space
    do_reset(32'hFFFF_FFFC);
    tick();
    check("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("wrap_inst", inst, 32'hEDCB_A984);
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    #1;
    check("wrap_pc_w_en", pc_w_en, 1);
    check("wrap_pc_in", pc_in, 32'h0000_0000);
    tick();
    inst_ready = 1'b0;

    // Reset asserted while waiting for a response
    tick();
    rst = 1'b0;
    #1;
    check("mid_req_valid", imem_req_valid, 0);
    check("mid_inst", inst, 0);
    check("mid_inst_pc", inst_pc, 0);
    check("mid_pc_w_en", pc_w_en, 0);
    tick();
    rst = 1'b1;
    check("mid_idle", imem_req_valid, 0);
    tick();
    check("mid_restart", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("mid_valid", inst_valid, 1);

`ifdef IFU_ALIGN_CHECK_EN
    // Misaligned fetch raises a fault without a memory request
    do_reset(32'h8000_0002);
    tick();
    check("al_req_valid", imem_req_valid, 0);
    tick();
    check("al_inst_valid", inst_valid, 1);
    check("al_fault", inst_fault, 1);
    check("al_inst_pc", inst_pc, 32'h8000_0002);
    check("al_inst", inst, 0);
    inst_ready = 1'b1;
    #1;
    check("al_pc_w_en", pc_w_en, 1);
    check("al_pc_in", pc_in, 32'h8000_0006);
    tick();
    inst_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
